keypad_key_fifo: RTL and testbench

Downstream consumer of the keypad encoder's registered d[3:0]/dav pair. Debounces dav and emits exactly one key event per physical press. Buffers key codes in a small first-word-fall-through FIFO that the host/display logic drains with a read strobe. Flags dropped keys with a sticky overflow bit.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_fifo_core.sv | 81 ++++++++
 rtl/keypad_key_fifo.sv | 186 ++++++++++++++++++
 tb/tb_keypad_key_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad path: key code width, the named key
//   codes produced by the encoder, and the debounce FSM state type.
package keypad_pkg;

  localparam int KEY_W = 4;

  // Codes emitted by the keypad encoder on d[3:0].
  localparam logic [KEY_W-1:0] KEY_0    = 4'h0;
  localparam logic [KEY_W-1:0] KEY_1    = 4'h1;
  localparam logic [KEY_W-1:0] KEY_2    = 4'h2;
  localparam logic [KEY_W-1:0] KEY_3    = 4'h3;
  localparam logic [KEY_W-1:0] KEY_4    = 4'h4;
  localparam logic [KEY_W-1:0] KEY_5    = 4'h5;
  localparam logic [KEY_W-1:0] KEY_6    = 4'h6;
  localparam logic [KEY_W-1:0] KEY_7    = 4'h7;
  localparam logic [KEY_W-1:0] KEY_8    = 4'h8;
  localparam logic [KEY_W-1:0] KEY_9    = 4'h9;
  localparam logic [KEY_W-1:0] KEY_STAR = 4'hE;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'hF;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/keypad_fifo_core.sv
// keypad_fifo_core
//   First-word-fall-through FIFO for key codes with a sticky overflow flag.
//
//   Handshake: push is accepted when the FIFO is not full, or when it is full
//   and a pop is accepted on the same edge; pop is accepted whenever the FIFO
//   is not empty. rd_data always shows the head entry (0 while empty).
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     push, push_data write request and data
//     pop             remove head entry (ignored when empty)
//     ovf_clr         clear sticky overflow (a same-cycle new overflow wins)
//     rd_data         head entry
//     empty, full     occupancy flags
//     count           occupancy, 0..DEPTH
//     overflow        sticky: a push was dropped because the FIFO was full
module keypad_fifo_core #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees the slot the push needs, so push+pop while full both succeed.
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly AW bits wide and DEPTH is a power of two, so they
  // wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Gating with empty keeps rd_data at 0 out of reset without resetting mem.
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo
//   Debounces the encoder's d/dav pair, emits one key event per press and
//   queues the key codes in a FWFT FIFO drained by rd_en.
//
//   Optional build macro: KEYPAD_AUTOREPEAT_EN
//     When defined, a held key re-issues its code after REPEAT_DELAY edges of
//     hold and then every REPEAT_PERIOD edges. When undefined, exactly one
//     event per press and no repeat logic exists.
//
//   Handshake: a key event pushes key_reg into the FIFO and pulses
//   press_pulse for one cycle after that edge, whether or not the FIFO had
//   room. rd_en pops the head on the edge it is sampled, if not empty.
//
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     d, dav       key code and key-down level from the encoder
//     rd_en        pop FIFO head
//     ovf_clr      clear sticky overflow
//     rd_data      FIFO head
//     empty, full, count, overflow   FIFO status
//     key_held     debounced key-down state
//     press_pulse  one-cycle strobe per accepted key event
//     state_dbg    current debounce FSM state
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 8,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [KEY_W-1:0]       d,
  input  logic                   dav,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic [KEY_W-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   key_held,
  output logic                   press_pulse,
  output key_state_t             state_dbg
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds the number of stable samples already seen, so the sample that
  // completes the debounce window arrives when cnt == DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [KEY_W-1:0] key_reg, key_nx;
  logic             press_push;
  logic             rpt_push;
  logic             push_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_reg     <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      key_reg     <= key_nx;
      press_pulse <= push_any;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    key_nx     = key_reg;
    press_push = 1'b0;
    case (state)
      IDLE: begin
        if (dav) begin
          key_nx   = d;
          cnt_nx   = CNT_W'(1);
          state_nx = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!dav || (d != key_reg)) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          press_push = 1'b1;
          cnt_nx     = '0;
          state_nx   = HELD;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD: begin
        // d changes while the key stays down are ignored on purpose.
        if (!dav) begin
          cnt_nx   = CNT_W'(1);
          state_nx = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (dav) begin
          cnt_nx   = '0;
          state_nx = HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             rpt_hit;

  // rpt_cnt counts HELD edges with dav high since entry or since the last
  // repeat; the first target is the initial delay, later ones the period.
  assign rpt_hit = (state == HELD) && dav &&
                   (rpt_cnt == (rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                          : RPT_W'(REPEAT_PERIOD - 1)));

  // Holding the counter cleared outside HELD restarts the repeat timing on
  // every entry, including the return from a release bounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != HELD) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (dav) begin
      if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign rpt_push = rpt_hit;
`else
  // Keeps the repeat parameters referenced in builds without auto-repeat.
  logic unused_rpt_params;
  assign unused_rpt_params = ((REPEAT_DELAY + REPEAT_PERIOD) == 0);
  assign rpt_push = 1'b0;
`endif

  assign push_any  = press_push | rpt_push;
  assign key_held  = (state == HELD) || (state == RELEASE_WAIT);
  assign state_dbg = state;

  keypad_fifo_core #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_any),
    .push_data (key_reg),
    .pop       (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_keypad_key_fifo.sv
// tb_keypad_key_fifo
//   Self-checking bench for keypad_key_fifo with DEBOUNCE_CYCLES=4, DEPTH=4,
//   REPEAT_DELAY=8, REPEAT_PERIOD=3. The reference model describes presses
//   as runs of stable samples and the FIFO as a queue.
module tb_keypad_key_fifo;
  import keypad_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RP    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [KEY_W-1:0] d = '0;
  logic             dav = 1'b0;
  logic             rd_en = 1'b0;
  logic             ovf_clr = 1'b0;
  logic [KEY_W-1:0] rd_data;
  logic             empty, full, overflow, key_held, press_pulse;
  logic [CW-1:0]    count;
  key_state_t       state_dbg;

  always #5 clk = ~clk;

  keypad_key_fifo #(
    .DEBOUNCE_CYCLES (N),
    .DEPTH           (DEPTH),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .dav         (dav),
    .rd_en       (rd_en),
    .ovf_clr     (ovf_clr),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .key_held    (key_held),
    .press_pulse (press_pulse),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       empty;
    logic       full;
    int         count;
    logic       overflow;
    logic       key_held;
    logic       press_pulse;
    logic       has_head;
    logic [3:0] head;
  } stat_t;

  stat_t            stat_q[$];
  logic [KEY_W-1:0] exp_q[$];
  int               checks = 0;
  int               failures = 0;
  bit               mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_q[$];
  bit         m_ovf = 0;
  bit         m_held = 0;
  bit         m_pulse = 0;
  int         hi_run = 0;
  int         lo_run = 0;
  logic [3:0] m_key = '0;
  int         hold_t = 0;
  int         next_rep = RD;

  // Effect of one clock edge with the given inputs.
  task automatic model_edge(input bit rst, input bit dv, input logic [3:0] dd,
                            input bit rd, input bit clr);
    bit ev;
    bit drop;
    ev = 0;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_held = 0; m_pulse = 0;
      hi_run = 0; lo_run = 0; m_key = '0;
      hold_t = 0; next_rep = RD;
      return;
    end
    if (!m_held) begin
      // A press is N consecutive high samples with an unchanged code; a
      // code change abandons the run and the next high sample starts over.
      if (!dv)              hi_run = 0;
      else if (hi_run == 0) begin m_key = dd; hi_run = 1; end
      else if (dd != m_key) hi_run = 0;
      else                  hi_run++;
      if (hi_run == N) begin
        ev = 1; m_held = 1; hi_run = 0; lo_run = 0;
        hold_t = 0; next_rep = RD;
      end
    end else if (!dv) begin
      lo_run++;
      if (lo_run == N) begin m_held = 0; lo_run = 0; end
    end else if (lo_run > 0) begin
      // Release bounce: key is down again, repeat timing restarts.
      lo_run = 0; hold_t = 0; next_rep = RD;
    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_t++;
      if (hold_t == next_rep) begin ev = 1; next_rep += RP; end
`endif
    end
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    drop = 0;
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_key);
      else drop = 1;
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_pulse = ev;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives inputs for the next rising edge and
  // records what the DUT must show after it.
  task automatic cycle(input bit rst, input bit dv, input logic [3:0] dd,
                       input bit rd, input bit clr);
    stat_t s;
    reset = rst; dav = dv; d = dd; rd_en = rd; ovf_clr = clr;
    if (!rst && rd && m_q.size() > 0) exp_q.push_back(m_q[0]);
    model_edge(rst, dv, dd, rd, clr);
    s.empty       = (m_q.size() == 0);
    s.full        = (m_q.size() == DEPTH);
    s.count       = m_q.size();
    s.overflow    = m_ovf;
    s.key_held    = m_held;
    s.press_pulse = m_pulse;
    s.has_head    = (m_q.size() > 0);
    s.head        = (m_q.size() > 0) ? m_q[0] : 4'h0;
    stat_q.push_back(s);
    @(negedge clk);
  endtask

  task automatic run(input bit dv, input logic [3:0] dd, input int n);
    repeat (n) cycle(0, dv, dd, 0, 0);
  endtask

  task automatic press(input logic [3:0] k);
    run(1, k, 6);
    run(0, 4'h0, 5);
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    stat_t e;
    #1;
    if (mon_en && stat_q.size() > 0) begin
      e = stat_q.pop_front();
      check("empty", empty, e.empty);
      check("full", full, e.full);
      check("count", count, e.count);
      check("overflow", overflow, e.overflow);
      check("key_held", key_held, e.key_held);
      check("press_pulse", press_pulse, e.press_pulse);
      if (e.has_head) check("head", rd_data, e.head);
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && rd_en && !empty && !reset) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_unexpected actual=%0d expected=none at %0t", rd_data, $time);
      end else begin
        check("read_data", rd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    mon_en = 1;
    cycle(1, 0, 4'h0, 0, 0);
    cycle(1, 1, 4'h3, 0, 0);
    cycle(0, 0, 4'h0, 0, 0);

    // Clean press, then read it back.
    run(1, KEY_5, 10);
    run(0, 4'h0, 6);
    cycle(0, 0, 4'h0, 1, 0);

    // Glitches: short high run, and a code change during debounce.
    run(1, KEY_7, 3);
    run(0, 4'h0, 3);
    run(1, KEY_5, 1);
    run(1, KEY_6, 1);
    run(0, 4'h0, 3);

    // Release bounce, single event expected; read it.
    run(1, KEY_9, 5);
    run(0, 4'h0, 1);
    run(1, KEY_9, 1);
    run(0, 4'h0, 6);
    cycle(0, 0, 4'h0, 1, 0);

    // Overflow with five presses, clear, drain, read while empty.
    for (int k = 1; k <= 5; k++) press(4'(k));
    cycle(0, 0, 4'h0, 0, 1);
    repeat (5) cycle(0, 0, 4'h0, 1, 0);

    // Push+pop while full.
    for (int k = 1; k <= 4; k++) press(4'(k));
    run(1, KEY_6, 3);
    cycle(0, 1, KEY_6, 1, 0);
    run(1, KEY_6, 2);
    run(0, 4'h0, 5);

    // New overflow and ovf_clr in the same cycle.
    run(1, KEY_STAR, 3);
    cycle(0, 1, KEY_STAR, 0, 1);
    run(0, 4'h0, 5);
    repeat (5) cycle(0, 0, 4'h0, 1, 0);

    // Reset in the middle of a debounce with the key still down.
    run(1, KEY_3, 2);
    cycle(1, 1, KEY_3, 0, 0);
    run(1, KEY_3, 6);
    run(0, 4'h0, 5);
    cycle(0, 0, 4'h0, 1, 0);

    // Long hold (auto-repeat when enabled), then drain.
    run(1, KEY_HASH, 22);
    run(0, 4'h0, 5);
    repeat (5) cycle(0, 0, 4'h0, 1, 0);
    cycle(0, 0, 4'h0, 0, 1);

    // Randomized segments of high/low levels with occasional code changes.
    repeat (80) begin
      int         len;
      bit         lvl;
      logic [3:0] k;
      len = $urandom_range(1, 7);
      lvl = 1'($urandom_range(0, 1));
      k   = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) k = 4'($urandom_range(0, 15));
        cycle(0, lvl, k, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end
    end
    repeat (6) cycle(0, 0, 4'h0, 1, 0);

    @(posedge clk);
    #3;
    check("reads_left", exp_q.size(), 0);
    check("status_left", stat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
